// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 lights a segment).
package seg7_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Non-decimal codes (10-15) show a dash so corrupt input is visible.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Pattern lookup
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered
// digits and a blank guard interval at the start of every slot.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking.
// GUARD must be >= 1 and PRESCALE > GUARD.
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digitsIn,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frameDone
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_pend;
  logic            r_pend_vld;
  logic [DW-1:0]   r_disp;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_wrap;
  logic [DW-1:0]   w_disp_nxt;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg_dec;
  logic            w_lz_blank;
  logic            w_show;

  // Slot sequencing: GUARD for counts 0..GUARD-1, DRIVE up to PRESCALE-1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    case (r_state)
      ST_GUARD: begin
        if (r_cnt == CW'(GUARD - 1)) w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (r_cnt == CW'(PRESCALE - 1)) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = '0;
          if (r_idx == IW'(NUM_DIGITS - 1)) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_GUARD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A same-cycle load at the wrap bypasses the pending buffer
  assign w_disp_nxt = w_wrap ? (load ? digitsIn : (r_pend_vld ? r_pend : r_disp))
                             : r_disp;

  // Outputs are computed from next-state values so seg/an move on the same
  // edge as the slot transition, with no input-to-pin combinational path.
  assign w_digit = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

`ifdef SEG7_LZB_EN
  // Suppress digit i>0 when it and every digit above it are zero
  always_comb begin
    w_lz_blank = 1'b0;
    if (w_idx_nxt != '0) begin
      w_lz_blank = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((IW'(i) >= w_idx_nxt) && (w_disp_nxt[4*i +: 4] != 4'd0))
          w_lz_blank = 1'b0;
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_show = (w_state_nxt == ST_DRIVE) && !blank && !w_lz_blank;

  // Scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Double buffer: pending collects loads, display swaps only at frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_disp     <= '0;
    end else begin
      if (load) r_pend <= digitsIn;
      if (w_wrap) begin
        r_disp     <= w_disp_nxt;
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Registered pin drivers and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg       <= SEG_OFF;
      an        <= '1;
      frameDone <= 1'b0;
    end else begin
      seg       <= w_show ? w_seg_dec : SEG_OFF;
      an        <= w_show ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
      frameDone <= w_wrap;
    end
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 7-segment display driver that consumes the packed BCD digit outputs of the binary-to-BCD converters (up to five digits: ten-thousands down to ones) and scans them onto a common-anode multiplexed display. Digits are double-buffered so a new value never tears mid-frame. A per-slot guard interval suppresses ghosting between digits. The block sits directly downstream of the BCD converter and drives board pins.

## Interface
- NUM_DIGITS, 5, digits scanned (1..8); digit 0 = ones
- PRESCALE, 50000, clock cycles per digit slot (must be > GUARD, ≥ 3)
- GUARD, 2, cycles at start of each slot with all anodes inactive
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture digitsIn into pending buffer this cycle
- digitsIn  in  4*NUM_DIGITS  packed BCD, digit i in [4i+3:4i]
- blank  in  1  force all anodes inactive (scan keeps running)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving, registered
- frameDone  out  1  one-cycle pulse at frame wrap

## Operation
- Registers: pending buffer, pendingValid flag, display buffer, digit index, slot counter, state.
- load=1: pending <= digitsIn, pendingValid <= 1. Last load before a wrap wins.
- FSM per slot: GUARD (counter 0..GUARD-1, an all inactive, seg all off) -> DRIVE (counter GUARD..PRESCALE-1, an[index] active, seg = decode(display[index])) -> GUARD of next index.
- Index increments at end of each DRIVE; from NUM_DIGITS-1 it wraps to 0.
- On wrap: display <= pending if pendingValid (or digitsIn if load is asserted the same cycle — load wins), pendingValid <= 0, frameDone = 1 for that cycle.
- Decode: 0-9 standard patterns; 10-15 show dash (g only, seg = 7'b0111111).
- blank=1: an all inactive, seg all off; counters, buffers, and frameDone are unaffected.
- Reset (any time, asynchronous): state GUARD, index 0, counter 0, pending/display = 0, pendingValid 0, seg = 7'h7F, an all 1s, frameDone 0. A mid-frame reset discards the frame immediately.

## Timing
- Slot = PRESCALE cycles; frame = NUM_DIGITS*PRESCALE cycles.
- seg/an change on the same edge as the state transition (registered, no combinational path from inputs).
- Load-to-display latency: ≤ one frame + GUARD + 1 cycle; the new value first appears at digit 0 DRIVE after the next wrap.
- frameDone is asserted in the first GUARD cycle of digit 0; the first frame after reset produces no pulse until the first wrap.
- seg and an never show a new digit's pattern while the previous anode is active (GUARD ≥ 1 guarantees this).

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. Digit i>0 keeps its anode inactive during DRIVE if it and all higher digits in display are 0. Digit 0 is always shown. Slot timing is unchanged.
- Not defined: every digit is driven, including leading zeros.

## Structure
- Package seg7_pkg: state encoding (GUARD, DRIVE), SEG_OFF = 7'h7F, SEG_DASH, the 0-9 active-low pattern constants.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-bit decoder, instantiated once on the mux output.

## Test plan
All scenarios use PRESCALE=8, GUARD=2, NUM_DIGITS=5.
- Reset: assert rst mid-DRIVE -> on the same edge, an=5'b11111, seg=7'h7F, frameDone=0. After release, the first wrap occurs 40 cycles later.
- Load 20'h12345 -> after frameDone: 2 cycles all-off, then an=5'b11110 and seg=7'b0010010 for 6 cycles. Next slot shows an=5'b11101, seg=7'b0011001 ("4").
- Load 20'h00042 then 20'h00099 within one frame -> the current frame is unchanged; the next frame shows 00099 only. Load asserted on the wrap cycle -> that value is displayed directly.
- Digit value 4'hA in digit 2 -> seg=7'b0111111 during an=5'b11011.
- SEG7_LZB_EN with 20'h00042 -> only an[0] and an[1] ever go low. Without the macro -> all five go low once per frame, and 0 digits show 7'b1000000.
- blank=1 for two frames -> an stays 5'b11111 throughout, and frameDone still pulses every 40 cycles.
